// File: rtl/alu_req_arbiter.sv
// Purpose  : shares one external 4-bit combinational ALU between two requesters. It uses
//            round-robin arbitration and returns each result on a response channel tagged
//            with the requester ID.
// Latency  : an accept at edge T gives rsp_valid from edge T+ALU_LAT. With rsp_ready held
//            high, one operation completes every ALU_LAT+2 cycles.
// Backpress: rsp_valid/rsp_id/rsp_data hold until rsp_ready is sampled. Requests are only
//            accepted in IDLE, so the requesters stall while an operation is in flight.
// Ports    : clk/rst (sync, active-high); req{0,1}_valid/ready/op/a/b/cin request channels;
//            alu_s/a/b/cin registered ALU drive, alu_c ALU result; rsp_valid/ready/id/data
//            response channel; busy (EXEC or RESP); ops_done completed-handshake counter.
module alu_req_arbiter #(
   parameter int ALU_LAT = 1,   // legal range 1..15
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4:0]       req0_op,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4:0]       req1_op,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   input  logic             req1_cin,
   output logic [4:0]       alu_s,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic             alu_cin,
   input  logic [4:0]       alu_c,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [4:0]       rsp_data,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic [3:0]       cnt_d;
   logic             last_grant_q;
   logic [4:0]       alu_s_q;
   logic [3:0]       alu_a_q;
   logic [3:0]       alu_b_q;
   logic             alu_cin_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [4:0]       rsp_data_q;
   logic [CNT_W-1:0] ops_done_q;
   logic [CNT_W-1:0] ops_done_d;
   logic             gnt0;
   logic             gnt1;

   // Grants are only offered in IDLE. On a tie the requester that did not win last time
   // is granted, which makes continuous contention alternate 0,1,0,1.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign cnt_d      = cnt_q - 4'd1;
   assign ops_done_d = ops_done_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         last_grant_q <= 1'b1;
         alu_s_q      <= 5'd0;
         alu_a_q      <= 4'd0;
         alu_b_q      <= 4'd0;
         alu_cin_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= 5'd0;
         ops_done_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  alu_s_q      <= gnt1 ? req1_op  : req0_op;
                  alu_a_q      <= gnt1 ? req1_a   : req0_a;
                  alu_b_q      <= gnt1 ? req1_b   : req0_b;
                  alu_cin_q    <= gnt1 ? req1_cin : req0_cin;
                  rsp_id_q     <= gnt1;
                  last_grant_q <= gnt1;
                  cnt_q        <= CNT_LOAD;
                  state_q      <= EXEC;
               end
            end
            EXEC: begin
               // The ALU inputs have been stable for ALU_LAT cycles once the counter reaches 0.
               if (cnt_q == 4'd0) begin
                  rsp_data_q  <= alu_c;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  ops_done_q  <= ops_done_d;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign alu_s      = alu_s_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign busy       = (state_q != IDLE);
   assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter. Instance "a" uses ALU_LAT=1 and CNT_W=8.
// Instance "b" uses ALU_LAT=3 and CNT_W=2. A small stand-in ALU drives alu_c on each instance.
module tb_alu_req_arbiter;

   logic clk;
   logic rst;

   // instance a
   logic       r0v, r0r, r0cin, r1v, r1r, r1cin;
   logic [4:0] r0op, r1op;
   logic [3:0] r0a, r0b, r1a, r1b;
   logic [4:0] as_, ac, rdat;
   logic [3:0] aa, ab;
   logic       acin, rv, rr, rid, bsy;
   logic [7:0] ops;

   // instance b
   logic       b0v, b0r, b0cin, b1v, b1r, b1cin;
   logic [4:0] b0op, b1op;
   logic [3:0] b0a, b0b, b1a, b1b;
   logic [4:0] bas, bac, brd;
   logic [3:0] baa, bab;
   logic       bacin, brv, brr, bid, bbsy;
   logic [1:0] bops;

   int n_tests;
   int n_fail;

   function automatic logic [4:0] alu_f(input logic [4:0] s, input logic [3:0] a,
                                        input logic [3:0] b, input logic ci);
      case (s)
         5'b00000: return {1'b0, a} + {1'b0, b} + {4'b0, ci};
         5'b00001: return {1'b0, a} + 5'd1;
         5'b00011: return {a, 1'b0};
         5'b10000: return {1'b0, a & b};
         default:  return {1'b0, a ^ b};
      endcase
   endfunction

   assign ac  = alu_f(as_, aa, ab, acin);
   assign bac = alu_f(bas, baa, bab, bacin);

   alu_req_arbiter #(.ALU_LAT(1), .CNT_W(8)) u_dut_a (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
      .req0_cin(r0cin),
      .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
      .req1_cin(r1cin),
      .alu_s(as_), .alu_a(aa), .alu_b(ab), .alu_cin(acin), .alu_c(ac),
      .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_data(rdat),
      .busy(bsy), .ops_done(ops)
   );

   alu_req_arbiter #(.ALU_LAT(3), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(b0v), .req0_ready(b0r), .req0_op(b0op), .req0_a(b0a), .req0_b(b0b),
      .req0_cin(b0cin),
      .req1_valid(b1v), .req1_ready(b1r), .req1_op(b1op), .req1_a(b1a), .req1_b(b1b),
      .req1_cin(b1cin),
      .alu_s(bas), .alu_a(baa), .alu_b(bab), .alu_cin(bacin), .alu_c(bac),
      .rsp_valid(brv), .rsp_ready(brr), .rsp_id(bid), .rsp_data(brd),
      .busy(bbsy), .ops_done(bops)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [4:0] exp_dat [4];
      logic [1:0] exp_bops [4];
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      r0v = 0; r0op = 0; r0a = 0; r0b = 0; r0cin = 0;
      r1v = 0; r1op = 0; r1a = 0; r1b = 0; r1cin = 0; rr = 0;
      b0v = 0; b0op = 0; b0a = 0; b0b = 0; b0cin = 0;
      b1v = 0; b1op = 0; b1a = 0; b1b = 0; b1cin = 0; brr = 0;
      step();
      step();
      rst = 1'b0;

      // ---- reset state
      chk("rst_rsp_valid", rv, 0);
      chk("rst_busy", bsy, 0);
      chk("rst_ops", ops, 0);
      chk("rst_alu_s", as_, 0);
      chk("rst_alu_a", aa, 0);
      chk("rst_rsp_id", rid, 0);
      chk("rst_rsp_data", rdat, 0);
      chk("rst_ready0", r0r, 0);
      chk("rst_b_ops", bops, 0);

      // ---- 1: single req0 add 9+8
      r0v = 1; r0op = 5'b00000; r0a = 4'h9; r0b = 4'h8; r0cin = 0; rr = 1;
      #1;
      chk("t1_ready0", r0r, 1);
      chk("t1_ready1", r1r, 0);
      step();
      r0v = 0;
      chk("t1_exec_busy", bsy, 1);
      chk("t1_exec_rv", rv, 0);
      chk("t1_alu_a", aa, 4'h9);
      chk("t1_alu_b", ab, 4'h8);
      step();
      chk("t1_rv", rv, 1);
      chk("t1_id", rid, 0);
      chk("t1_data", rdat, 5'h11);
      step();
      chk("t1_rv_clr", rv, 0);
      chk("t1_ops", ops, 1);
      chk("t1_idle", bsy, 0);

      // ---- 2: both requesters continuously valid
      rst = 1; step(); rst = 0;
      r0v = 1; r0op = 5'b00011; r0a = 4'hB; r0b = 4'h0; r0cin = 0;
      r1v = 1; r1op = 5'b10000; r1a = 4'hC; r1b = 4'hA; r1cin = 0;
      rr = 1;
      exp_dat[0] = 5'h16; exp_dat[1] = 5'h08; exp_dat[2] = 5'h16; exp_dat[3] = 5'h08;
      #1;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 8; c++) begin
            if (r0r || r1r) break;
            step();
         end
         chk("t2_grant_seen", r0r | r1r, 1);
         chk("t2_one_hot", r0r & r1r, 0);
         chk("t2_grant_id", r1r, i % 2);
         step();
         for (int c = 0; c < 8; c++) begin
            if (rv) break;
            step();
         end
         chk("t2_rv_seen", rv, 1);
         chk("t2_id", rid, i % 2);
         chk("t2_data", rdat, exp_dat[i]);
         step();
      end
      r0v = 0; r1v = 0;
      chk("t2_ops", ops, 4);

      // ---- 3: backpressure on req1 increment of F
      r1v = 1; r1op = 5'b00001; r1a = 4'hF; r1b = 4'h0; r1cin = 0; rr = 0;
      #1;
      chk("t3_ready1", r1r, 1);
      step();
      r1v = 0;
      step();
      chk("t3_rv", rv, 1);
      r0v = 1; r0op = 5'b00000; r0a = 4'h1; r0b = 4'h2; r0cin = 0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("t3_hold_rv", rv, 1);
         chk("t3_hold_data", rdat, 5'h10);
         chk("t3_hold_id", rid, 1);
         chk("t3_no_accept", r0r, 0);
         step();
      end
      rr = 1;
      #1;
      chk("t3_no_accept_hs", r0r, 0);
      step();
      chk("t3_rv_clr", rv, 0);
      chk("t3_ops", ops, 5);
      chk("t3_accept_after", r0r, 1);
      step();
      r0v = 0;
      step();
      chk("t3_rv2", rv, 1);
      chk("t3_data2", rdat, 5'h03);
      chk("t3_id2", rid, 0);
      step();
      chk("t3_ops2", ops, 6);

      // ---- 5: reset during EXEC, then during RESP
      r0v = 1; r0op = 5'b00000; r0a = 4'h1; r0b = 4'h1; r0cin = 0;
      #1;
      step();
      r0v = 0;
      chk("t5_exec_busy", bsy, 1);
      rst = 1;
      step();
      rst = 0;
      chk("t5_exec_rv", rv, 0);
      chk("t5_exec_busy_clr", bsy, 0);
      chk("t5_exec_ops", ops, 0);
      r0v = 1; rr = 0;
      #1;
      step();
      r0v = 0;
      step();
      chk("t5_resp_rv", rv, 1);
      rst = 1; rr = 1;
      step();
      rst = 0; rr = 0;
      chk("t5_resp_rv_clr", rv, 0);
      chk("t5_resp_ops", ops, 0);
      chk("t5_resp_busy", bsy, 0);
      r0v = 1; r1v = 1;
      #1;
      chk("t5_tie_ready0", r0r, 1);
      chk("t5_tie_ready1", r1r, 0);
      step();
      r0v = 0; r1v = 0; rr = 1;
      step();
      step();
      chk("t5_ops_after", ops, 1);

      // ---- 4: ALU_LAT=3 latency and ALU drive stability
      b0v = 1; b0op = 5'b00000; b0a = 4'h3; b0b = 4'h4; b0cin = 1; brr = 0;
      #1;
      chk("t4_ready", b0r, 1);
      step();
      b0v = 0; b0op = 5'h1f; b0a = 4'hF; b0b = 4'h0; b0cin = 0;
      chk("t4_T0_rv", brv, 0);
      chk("t4_T0_alu_a", baa, 4'h3);
      step();
      chk("t4_T1_rv", brv, 0);
      chk("t4_T1_alu_b", bab, 4'h4);
      step();
      chk("t4_T2_rv", brv, 0);
      step();
      chk("t4_T3_rv", brv, 1);
      chk("t4_T3_data", brd, 5'h08);
      chk("t4_T3_alu_cin", bacin, 1);
      step();
      chk("t4_resp_rv", brv, 1);
      chk("t4_resp_alu_s", bas, 5'h00);
      chk("t4_resp_alu_a", baa, 4'h3);
      chk("t4_resp_alu_b", bab, 4'h4);
      brr = 1;
      step();
      chk("t4_rv_clr", brv, 0);
      chk("t6_ops_1", bops, 2'd1);

      // ---- 6: CNT_W=2 wrap
      exp_bops[0] = 2'd2; exp_bops[1] = 2'd3; exp_bops[2] = 2'd0; exp_bops[3] = 2'd1;
      b0op = 5'b00000; b0a = 4'h3; b0b = 4'h4; b0cin = 1;
      for (int i = 0; i < 4; i++) begin
         b0v = 1;
         #1;
         step();
         b0v = 0;
         for (int c = 0; c < 10; c++) begin
            if (brv) break;
            step();
         end
         chk("t6_rv_seen", brv, 1);
         step();
         chk("t6_ops", bops, exp_bops[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the 4-bit combinational ALU (5-bit opcode `s`, carry input, 5-bit result) between two independent requesters.
- Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin when both requesters are valid.
- Drives the ALU operands from registers, waits a fixed settle time, then captures the ALU result.
- Returns the result through a valid/ready response channel tagged with the requester ID. It sits between the two client blocks and the ALU instance.

Parameters:
- ALU_LAT, 1, cycles spent in EXEC before the result is captured; legal range 1..15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  5  requester 0 ALU opcode.
- req0_a  in  4  requester 0 operand A.
- req0_b  in  4  requester 0 operand B.
- req0_cin  in  1  requester 0 carry in.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- alu_s  out  5  opcode to ALU.
- alu_a  out  4  operand A to ALU.
- alu_b  out  4  operand B to ALU.
- alu_cin  out  1  carry in to ALU.
- alu_c  in  5  ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  5  captured ALU result.
- busy  out  1  high in EXEC or RESP.
- ops_done  out  CNT_W  count of completed response handshakes.

Behaviour:
- Reset (rst high at an edge):
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
  - alu_s/alu_a/alu_b/alu_cin = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, ops_done = 0, busy = 0, EXEC counter = 0.
  - Reset mid-operation abandons the operation: no response is produced and ops_done is not incremented.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational and only ever high in IDLE; at most one is high per cycle.
  - Only req0_valid high: req0_ready = 1. Only req1_valid high: req1_ready = 1.
  - Both valid: grant the requester != last_grant.
  - On grant, at the edge:
    - latch op/a/b/cin into alu_s/alu_a/alu_b/alu_cin;
    - set rsp_id = granted ID and last_grant = granted ID;
    - load the counter with ALU_LAT-1; go to EXEC.
  - Neither valid: stay in IDLE, hold all ALU drive registers.
- EXEC:
  - ALU drive registers held stable.
  - Counter decrements each cycle. On the cycle where the counter is 0: capture alu_c into rsp_data, set rsp_valid = 1, go to RESP.
  - req*_ready = 0 throughout.
- RESP:
  - rsp_valid, rsp_id and rsp_data held stable until rsp_ready is sampled high.
  - On handshake: rsp_valid = 0, ops_done += 1 (wraps modulo 2^CNT_W), go to IDLE.
  - ALU drive registers keep their values (not cleared).
- Latency and throughput:
  - Accept at edge T → rsp_valid high from edge T+ALU_LAT.
  - With rsp_ready held high, one operation completes every ALU_LAT+2 cycles.
  - No new request is accepted in the cycle a response handshake completes; acceptance resumes in the following IDLE cycle.
- Requester obligations:
  - A requester holds op/a/b/cin stable while valid is high and ready is low.
  - The block never inspects the opcode. Every 5-bit value is passed through, and results are returned verbatim, including bit 4.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1….

Test Plan:
1. Reset, then req0 only: op 5'b00000, a=4'h9, b=4'h8, cin=0 → req0_ready high for 1 cycle; rsp_valid at T+1 with rsp_id=0, rsp_data=5'h11; ops_done=1.
2. Both valid continuously for 4 operations: req0 op 5'b00011 (left shift) a=4'hB, req1 op 5'b10000 (AND) a=4'hC b=4'hA → grants 0,1,0,1; responses 5'h16 (id 0), 5'h08 (id 1), alternating; ops_done=4.
3. Backpressure: req1 op 5'b00001 (increment) a=4'hF; hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_data=5'h10 stable; req0_valid high is not accepted until one cycle after the handshake.
4. ALU_LAT=3: single request → rsp_valid asserts exactly 3 cycles after the accept edge; alu_* outputs constant across EXEC and RESP.
5. Reset asserted during EXEC, then during RESP → next cycle IDLE, rsp_valid=0, ops_done=0; a fresh simultaneous request grants requester 0 first.
6. CNT_W=2: 5 completed operations → ops_done reads 1,2,3,0,1.
